// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line-wide memory port between an I-cache and a
// D-cache. Grants are taken in IDLE, ties alternate between the two sides,
// and every transaction is followed by one RECOVER cycle with both strobes low.
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,

  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } state_t;

  // Low address bits that select a byte within a 16-byte line.
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(4'hF);

  state_t            state, state_next;
  logic              last_d, last_d_next;      // 1: D was granted last, 0: I
  logic              op_write, op_write_next;  // latched D operation
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [LINE_W-1:0] wdata_q, wdata_next;
  logic [CNT_W-1:0]  i_cnt_q, d_cnt_q;

  logic i_pend, d_pend, grant_i, grant_d;

  assign i_pend  = i_read;
  assign d_pend  = d_read | d_write;
  // On a tie D wins unless D was the side granted last time.
  assign grant_d = d_pend & (~i_pend | ~last_d);
  assign grant_i = i_pend & ~grant_d;

  // State, grant history and latched transaction registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      state    <= state_next;
      last_d   <= last_d_next;
      op_write <= op_write_next;
      addr_q   <= addr_next;
      wdata_q  <= wdata_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, wait for pmem_resp, then recover.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next    = state;
    last_d_next   = last_d;
    op_write_next = op_write;
    addr_next     = addr_q;
    wdata_next    = wdata_q;

    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_next    = SERVE_D;
          last_d_next   = 1'b1;
          addr_next     = d_addr & ~LINE_MASK;
          op_write_next = d_write;  // write wins over a simultaneous read
          if (d_write) begin
            wdata_next = d_wdata;
          end
        end else if (grant_i) begin
          state_next    = SERVE_I;
          last_d_next   = 1'b0;
          addr_next     = i_addr & ~LINE_MASK;
          op_write_next = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_next = RECOVER;
        end
      end
      RECOVER: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Saturating per-side completion counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      if (i_resp && (i_cnt_q != '1)) begin
        i_cnt_q <= i_cnt_q + 1'b1;
      end
      if (d_resp && (d_cnt_q != '1)) begin
        d_cnt_q <= d_cnt_q + 1'b1;
      end
    end
  end

  // Strobes follow the state directly, so reset drops them immediately.
  assign pmem_read   = (state == SERVE_I) | ((state == SERVE_D) & ~op_write);
  assign pmem_write  = (state == SERVE_D) & op_write;
  assign pmem_addr   = addr_q;
  assign pmem_wdata  = wdata_q;

  assign i_resp      = pmem_resp & (state == SERVE_I);
  assign d_resp      = pmem_resp & (state == SERVE_D);
  assign i_rdata     = pmem_rdata;
  assign d_rdata     = pmem_rdata;

  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, address width in bits.
REQ-002 Parameter LINE_W, 128, cache-line width (one lc3b_datbus).
REQ-003 Parameter CNT_W, 16, width of each grant counter.
REQ-004 Timing: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_read  in  1  I-side line fill request.
REQ-008 i_addr  in  ADDR_W  I-side request address.
REQ-009 i_rdata  out  LINE_W  I-side fill data.
REQ-010 i_resp  out  1  I-side completion pulse.
REQ-011 d_read  in  1  D-side line fill request.
REQ-012 d_write  in  1  D-side writeback request.
REQ-013 d_addr  in  ADDR_W  D-side request address.
REQ-014 d_wdata  in  LINE_W  D-side writeback data.
REQ-015 d_rdata  out  LINE_W  D-side fill data.
REQ-016 d_resp  out  1  D-side completion pulse.
REQ-017 pmem_read  out  1  shared-port read strobe.
REQ-018 pmem_write  out  1  shared-port write strobe.
REQ-019 pmem_addr  out  ADDR_W  shared-port address.
REQ-020 pmem_wdata  out  LINE_W  shared-port write data.
REQ-021 pmem_rdata  in  LINE_W  shared-port read data.
REQ-022 pmem_resp  in  1  shared-port completion, held high one cycle per transaction.
REQ-023 i_grant_cnt  out  CNT_W  count of completed I-side transactions.
REQ-024 d_grant_cnt  out  CNT_W  count of completed D-side transactions.

Function
REQ-025 FSM states: IDLE, SERVE_I, SERVE_D, RECOVER.
REQ-026 Request inputs are sampled only in IDLE.
- IDLE, only I pending -> SERVE_I.
- IDLE, only D pending (d_read|d_write) -> SERVE_D.
- IDLE, none pending -> stay in IDLE.
REQ-027 If I and D are both pending in IDLE, the side not granted last SHALL win (round-robin); the last-granted flag resets to I, so D wins the first tie.
REQ-028 The grant SHALL be latched in IDLE, and pmem strobes SHALL assert the cycle after the request is seen (one-cycle latency).
REQ-029 Address and write data latching on grant:
- Latch i_addr or d_addr with bits [3:0] forced to zero (line-aligned).
- For a D write, also latch d_wdata.
- pmem_addr and pmem_wdata are driven from these registers, not from the live inputs.
REQ-030 In SERVE_I: pmem_read=1 and pmem_write=0.
REQ-031 In SERVE_D: exactly one strobe is asserted, per the latched operation; if d_read and d_write were both high at grant, the write wins.
REQ-032 Strobes SHALL stay asserted until pmem_resp=1.
REQ-033 On pmem_resp the FSM SHALL go SERVE_x -> RECOVER.
REQ-034 RECOVER holds both strobes low for exactly one cycle, then goes to IDLE; back-to-back transactions are therefore separated by at least two strobe-low cycles (RECOVER + IDLE).
REQ-035 i_resp = pmem_resp & (state==SERVE_I); d_resp = pmem_resp & (state==SERVE_D); both are combinational and never high together.
REQ-036 i_rdata and d_rdata SHALL be combinational pass-throughs of pmem_rdata.
REQ-037 A requester that drops its request mid-transaction does not abort it; the transaction completes and the resp pulse is still issued.
REQ-038 Each grant counter increments by 1 on its side's resp and saturates at all-ones (no wrap).
REQ-039 pmem_resp seen in IDLE or RECOVER SHALL be ignored, with no state or counter change.

Reset
REQ-040 On reset_n=0, immediately and asynchronously:
- state=IDLE; last-granted=I.
- pmem_read, pmem_write, i_resp, d_resp = 0.
- Counters = 0; pmem_addr and pmem_wdata = 0.
REQ-041 Reset asserted mid-transaction SHALL drop strobes in the same cycle with no resp issued; after release, an outstanding request is re-arbitrated from IDLE.

Verification
REQ-042 I-only fill:
- Stimulus: i_read=1, i_addr=0x1236; pmem_resp on the 3rd strobe cycle.
- Required: pmem_addr=0x1230; pmem_read high 3 cycles; one i_resp pulse; i_grant_cnt=1.
REQ-043 Tie after reset:
- Stimulus: i_read=1 and d_read=1 together.
- Required: D served first, then I (via RECOVER and IDLE); second tie served to D again.
REQ-044 D writeback:
- Stimulus: d_write=1, d_wdata=0xA5..A5; d_wdata changed during the transaction.
- Required: pmem_write=1; pmem_wdata stays 0xA5..A5; d_resp pulses once.
REQ-045 Conflicting D ops:
- Stimulus: d_read=1 and d_write=1 together.
- Required: pmem_write=1 and pmem_read=0 throughout.
REQ-046 Reset mid-SERVE_I:
- Stimulus: reset_n=0 mid-SERVE_I; release with i_read still high.
- Required: strobes low with no i_resp; after release, a fresh grant with pmem_read asserted one cycle later.
REQ-047 Counter saturation:
- Stimulus: d_grant_cnt preloaded via forced transactions to 0xFFFF; one more D transaction.
- Required: d_grant_cnt stays 0xFFFF.
